// File: rtl/spi_pkg.sv
// Shared types and default parameters for the SPI master slice.
package spi_pkg;

  localparam int unsigned DEF_CLK_DIV = 4;
  localparam int unsigned DEF_DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick_c is high in the last cycle of each
// CLK_DIV-cycle window while enabled.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = en && (cnt_q == CNT_W'(CLK_DIV - 1));

  // Count cycles within the current half period, wrapping on tick.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_wrapper.sv
// Pad-level wrapper: maps the SPI pins onto a 4-bit io bus.
// io[0]=sclk, io[1]=mosi, io[2]=cs_n (outputs), io[3]=miso (input).
module spi_wrapper
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              hold_cs_i,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oeb,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o
);

  logic sclk;
  logic mosi;
  logic cs_n;
  logic unused_io;

  // Only io[3] is an input; the other pad inputs are don't-care.
  assign unused_io = ^io_in[2:0];

  spi_master_core #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) u_core (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .start_i   (start_i),
    .tx_data_i (tx_data_i),
    .hold_cs_i (hold_cs_i),
    .miso_i    (io_in[3]),
    .sclk_o    (sclk),
    .mosi_o    (mosi),
    .cs_n_o    (cs_n),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .rx_data_o (rx_data_o)
  );

  assign io_out = {1'b0, cs_n, mosi, sclk};
  assign io_oeb = 4'b1000;

endmodule

// File: rtl/spi_master_core.sv
// SPI mode-0 master: one DATA_W-bit full-duplex transfer per accepted start,
// optional chip-select hold between back-to-back transfers.
module spi_master_core
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              hold_cs_i,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              cs_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o
);

  localparam int unsigned EDGE_W    = $clog2(2 * DATA_W);
  localparam int unsigned LAST_EDGE = 2 * DATA_W - 1;

  spi_state_t        state_q, state_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              hold_q, hold_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_clr;
  logic              div_en;
  logic              tick;

  // The divider only runs while a transfer is timing SETUP/SHIFT/HOLD.
  assign div_en  = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                   (state_q == ST_HOLD);
  assign div_clr = wb_rst_i || !div_en;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (wb_clk_i),
    .clr    (div_clr),
    .en     (div_en),
    .tick_c (tick)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    hold_d  = hold_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mosi_d = 1'b0;
        if (start_i) begin
          state_d = ST_SETUP;
          tx_d    = tx_data_i;
          hold_d  = hold_cs_i;
          rx_sh_d = '0;
          edge_d  = '0;
          cs_n_d  = 1'b0;
          mosi_d  = tx_data_i[DATA_W-1];
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          if (!edge_q[0]) begin
            // Rising edge: sample the slave's bit.
            rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_i};
          end else if (edge_q == EDGE_W'(LAST_EDGE)) begin
            state_d = ST_HOLD;
            edge_d  = '0;
          end else begin
            // Falling edge: advance to the next TX bit.
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            mosi_d = tx_q[DATA_W-2];
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
          cs_n_d  = ~hold_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        mosi_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        cs_n_d  = 1'b1;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      hold_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      hold_q  <= hold_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_q;

endmodule
